// File: rtl/axi_pkg.sv
// Shared definitions for the round-robin stream arbiter: FSM encoding and id-width helpers.
package axi_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Id field never collapses to zero width, even for a single requester.
    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/axi_rr_arbiter_if.sv
// Bundle of the upstream request streams and the shared downstream stream of axi_rr_arbiter.
interface axi_rr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DWIDTH  = 8,
    parameter int IDW     = 2
);
    import axi_pkg::*;

    // Handshake: a beat transfers on a rising clock edge where valid and ready are both high;
    // the producer keeps data/last stable while valid is high and the beat is not yet taken.
    logic [NUM_REQ-1:0]        s_valid_i;
    logic [NUM_REQ-1:0]        s_ready_o;
    logic [NUM_REQ*DWIDTH-1:0] s_data_i;
    logic [NUM_REQ-1:0]        s_last_i;
    logic                      m_valid_o;
    logic                      m_ready_i;
    logic [DWIDTH-1:0]         m_data_o;
    logic                      m_last_o;
    logic [IDW-1:0]            m_id_o;

    modport slave (
        input  s_valid_i, s_data_i, s_last_i, m_ready_i,
        output s_ready_o, m_valid_o, m_data_o, m_last_o, m_id_o
    );

    modport master (
        output s_valid_i, s_data_i, s_last_i, m_ready_i,
        input  s_ready_o, m_valid_o, m_data_o, m_last_o, m_id_o
    );

endinterface

// File: rtl/axi_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping to index 0.
module rr_pick
    import axi_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic [NUM_REQ-1:0] gnt_onehot,
    output logic [IDW-1:0]     gnt_idx,
    output logic               gnt_any
);

    logic [NUM_REQ-1:0] masked;
    logic               hit_m;
    logic               hit_u;
    logic [IDW-1:0]     idx_m;
    logic [IDW-1:0]     idx_u;

    always_comb begin
        masked = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            masked[i] = req[i] && (i >= int'(ptr));
        end
    end

    // Scanning downward leaves the lowest set index as the final assignment.
    always_comb begin
        hit_m = 1'b0;
        idx_m = '0;
        hit_u = 1'b0;
        idx_u = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (masked[i]) begin
                hit_m = 1'b1;
                idx_m = IDW'(i);
            end
            if (req[i]) begin
                hit_u = 1'b1;
                idx_u = IDW'(i);
            end
        end
    end

    assign gnt_any    = hit_u;
    assign gnt_idx    = hit_m ? idx_m : idx_u;
    assign gnt_onehot = gnt_any ? (NUM_REQ'(1) << gnt_idx) : '0;

endmodule

// File: rtl/axi_rr_arbiter.sv
// Packet-granular round-robin arbiter with a single registered output stage.
// Optional per-requester packet counters are built when ARB_STATS_EN is defined.
module axi_rr_arbiter
    import axi_pkg::*;
#(
    parameter int  NUM_REQ = 4,
    parameter int  DWIDTH  = 8,
    localparam int IDW     = id_width(NUM_REQ)
) (
    input  logic                  aclk_i,
    input  logic                  aresetn_i,
`ifdef ARB_STATS_EN
    output logic [NUM_REQ*16-1:0] stats_pkts_o,
`endif
    output arb_state_t            dbg_state,
    axi_rr_arbiter_if.slave       bus
);

    arb_state_t         state;
    arb_state_t         state_nxt;
    logic [IDW-1:0]     rr_ptr;
    logic [IDW-1:0]     rr_ptr_nxt;
    logic [IDW-1:0]     lock_id;
    logic [IDW-1:0]     lock_id_nxt;

    logic [NUM_REQ-1:0] pick_oh;
    logic [IDW-1:0]     pick_idx;
    logic               pick_any;
    logic [NUM_REQ-1:0] grant_vec;
    logic [IDW-1:0]     win_idx;
    logic [NUM_REQ-1:0] accept_vec;
    logic               stage_free;
    logic               acc_any;
    logic               acc_last;
    logic [DWIDTH-1:0]  acc_data;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_pick (
        .req        (bus.s_valid_i),
        .ptr        (rr_ptr),
        .gnt_onehot (pick_oh),
        .gnt_idx    (pick_idx),
        .gnt_any    (pick_any)
    );

    assign stage_free = ~bus.m_valid_o | bus.m_ready_i;

    // While locked the owner keeps its grant even with valid low, so packets never get preempted.
    always_comb begin
        grant_vec = pick_oh;
        win_idx   = pick_idx;
        if (state == ARB_LOCKED) begin
            grant_vec = NUM_REQ'(1) << lock_id;
            win_idx   = lock_id;
        end
    end

    assign bus.s_ready_o = grant_vec & {NUM_REQ{stage_free}};
    assign accept_vec    = bus.s_valid_i & grant_vec & {NUM_REQ{stage_free}};
    assign acc_any       = |accept_vec;
    assign acc_last      = bus.s_last_i[win_idx];
    assign acc_data      = bus.s_data_i[win_idx*DWIDTH +: DWIDTH];
    assign dbg_state     = state;

    always_ff @(posedge aclk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            state   <= ARB_IDLE;
            rr_ptr  <= '0;
            lock_id <= '0;
        end else begin
            state   <= state_nxt;
            rr_ptr  <= rr_ptr_nxt;
            lock_id <= lock_id_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        rr_ptr_nxt  = rr_ptr;
        lock_id_nxt = lock_id;
        if (acc_any && acc_last) begin
            state_nxt  = ARB_IDLE;
            rr_ptr_nxt = (win_idx == IDW'(NUM_REQ - 1)) ? '0 : win_idx + IDW'(1);
        end else if (acc_any && (state == ARB_IDLE)) begin
            state_nxt   = ARB_LOCKED;
            lock_id_nxt = win_idx;
        end
    end

    always_ff @(posedge aclk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            bus.m_valid_o <= 1'b0;
            bus.m_data_o  <= '0;
            bus.m_last_o  <= 1'b0;
            bus.m_id_o    <= '0;
        end else if (acc_any) begin
            bus.m_valid_o <= 1'b1;
            bus.m_data_o  <= acc_data;
            bus.m_last_o  <= acc_last;
            bus.m_id_o    <= win_idx;
        end else if (bus.m_valid_o && bus.m_ready_i) begin
            bus.m_valid_o <= 1'b0;
        end
    end

`ifdef ARB_STATS_EN
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_stats
        logic [15:0] cnt;
        always_ff @(posedge aclk_i or negedge aresetn_i) begin
            if (!aresetn_i) begin
                cnt <= '0;
            end else if (accept_vec[k] && bus.s_last_i[k] && (cnt != 16'hFFFF)) begin
                cnt <= cnt + 16'd1;
            end
        end
        assign stats_pkts_o[k*16 +: 16] = cnt;
    end
`endif

    // Upstream must hold a pending beat steady until it is taken.
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_contract
        a_hold_stable : assert property (@(posedge aclk_i) disable iff (!aresetn_i)
            (bus.s_valid_i[k] && !bus.s_ready_o[k]) |=>
            (!bus.s_valid_i[k] || ($stable(bus.s_data_i[k*DWIDTH +: DWIDTH]) && $stable(bus.s_last_i[k]))));
    end

endmodule

// File: tb/tb_axi_rr_arbiter.sv
// Self-checking bench for axi_rr_arbiter: per-requester sources, a round-robin reference and an expected-beat queue.
module tb_axi_rr_arbiter;
    import axi_pkg::*;

    localparam int NR  = 4;
    localparam int DW  = 8;
    localparam int IDW = 2;
    localparam int W   = IDW + 1 + DW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_rr_arbiter_if #(.NUM_REQ(NR), .DWIDTH(DW), .IDW(IDW)) bus ();
    arb_state_t dbg_state;
`ifdef ARB_STATS_EN
    logic [NR*16-1:0] stats;
`endif

    axi_rr_arbiter #(.NUM_REQ(NR), .DWIDTH(DW)) dut (
        .aclk_i       (clk),
        .aresetn_i    (rst_n),
`ifdef ARB_STATS_EN
        .stats_pkts_o (stats),
`endif
        .dbg_state    (dbg_state),
        .bus          (bus)
    );

    logic [DW:0]     src_mem [NR][64];
    int              src_rd [NR];
    int              src_wr [NR];
    logic [NR-1:0]   en;
    int              mdl_ptr;
    int              mdl_lock;
    bit              mdl_locked;
    bit              mdl_mvalid;
    logic [W-1:0]    exp_q [$];
    int              out_ids [$];
    logic [DW-1:0]   out_data [$];
    int              checks = 0;
    int              failures = 0;

    task automatic clear_model();
        for (int k = 0; k < NR; k++) begin
            src_rd[k] = 0;
            src_wr[k] = 0;
        end
        mdl_ptr    = 0;
        mdl_lock   = 0;
        mdl_locked = 0;
        mdl_mvalid = 0;
        exp_q.delete();
    endtask

    task automatic push_beat(input int k, input logic [DW-1:0] d, input logic l);
        src_mem[k][src_wr[k]] = {l, d};
        src_wr[k]++;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.s_valid_i = '0;
        en = '0;
        clear_model();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock: drive sources, compare against the reference, then advance to the next falling edge.
    task automatic cycle();
        int w;
        logic [NR-1:0] exp_rdy;
        logic [W-1:0]  got;
        logic [W-1:0]  exp;
        logic [IDW-1:0] wid;
        for (int k = 0; k < NR; k++) begin
            bus.s_valid_i[k] = en[k] && (src_rd[k] != src_wr[k]);
            bus.s_data_i[k*DW +: DW] = bus.s_valid_i[k] ? src_mem[k][src_rd[k]][DW-1:0] : '0;
            bus.s_last_i[k] = bus.s_valid_i[k] ? src_mem[k][src_rd[k]][DW] : 1'b0;
        end
        #2;
        w = -1;
        if (mdl_locked) begin
            w = mdl_lock;
        end else begin
            for (int i = 0; i < NR; i++) begin
                if (w < 0 && bus.s_valid_i[(mdl_ptr + i) % NR]) w = (mdl_ptr + i) % NR;
            end
        end
        exp_rdy = '0;
        if (w >= 0 && (!mdl_mvalid || bus.m_ready_i)) exp_rdy[w] = 1'b1;
        checks++;
        if (bus.s_ready_o !== exp_rdy) begin
            failures++;
            $display("FAIL s_ready: got %b expected %b", bus.s_ready_o, exp_rdy);
        end
        checks++;
        if (bus.m_valid_o !== mdl_mvalid) begin
            failures++;
            $display("FAIL m_valid: got %b expected %b", bus.m_valid_o, mdl_mvalid);
        end
        if (mdl_mvalid && bus.m_ready_i) begin
            got = {bus.m_id_o, bus.m_last_o, bus.m_data_o};
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL out_beat: got %h with no beat expected", got);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    failures++;
                    $display("FAIL out_beat: got %h expected %h", got, exp);
                end
            end
            out_ids.push_back(int'(bus.m_id_o));
            out_data.push_back(bus.m_data_o);
        end
        if (exp_rdy != '0 && bus.s_valid_i[w]) begin
            wid = IDW'(w);
            exp_q.push_back({wid, src_mem[w][src_rd[w]]});
            if (src_mem[w][src_rd[w]][DW]) begin
                mdl_locked = 0;
                mdl_ptr = (w + 1) % NR;
            end else begin
                mdl_locked = 1;
                mdl_lock = w;
            end
            src_rd[w]++;
            mdl_mvalid = 1;
        end else if (mdl_mvalid && bus.m_ready_i) begin
            mdl_mvalid = 0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input int max);
        int n;
        bit pending;
        n = 0;
        pending = 1;
        while (pending && n < max) begin
            pending = (exp_q.size() > 0) || mdl_mvalid;
            for (int k = 0; k < NR; k++) if (en[k] && src_rd[k] != src_wr[k]) pending = 1;
            if (pending) begin
                cycle();
                n++;
            end
        end
        if (pending) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: %0d beats still pending after %0d cycles", exp_q.size(), max);
        end
    endtask

    task automatic test_reset();
        bus.m_ready_i = 1'b1;
        bus.s_data_i  = '0;
        bus.s_last_i  = '0;
        apply_reset();
        checks++;
        if ({bus.m_valid_o, bus.m_last_o, bus.m_id_o, bus.m_data_o} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got v=%b l=%b id=%0d d=%h expected all zero",
                     bus.m_valid_o, bus.m_last_o, bus.m_id_o, bus.m_data_o);
        end
        checks++;
        if (dbg_state !== ARB_IDLE) begin
            failures++;
            $display("FAIL reset_state: got %0d expected IDLE", dbg_state);
        end
        for (int i = 0; i < 10; i++) begin
            cycle();
            checks++;
            if (bus.s_ready_o !== 4'b0000 || bus.m_valid_o !== 1'b0) begin
                failures++;
                $display("FAIL idle_quiet: got ready=%b valid=%b expected 0000/0", bus.s_ready_o, bus.m_valid_o);
            end
        end
    endtask

    task automatic test_round_robin();
        int base;
        apply_reset();
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < NR; k++) push_beat(k, DW'(8'h10 + k), 1'b1);
        en = 4'hF;
        base = out_ids.size();
        repeat (9) cycle();
        checks++;
        if (out_ids.size() - base != 8) begin
            failures++;
            $display("FAIL rr_throughput: got %0d beats expected 8 in 9 cycles", out_ids.size() - base);
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (out_ids[base+i] != i % 4 || out_data[base+i] !== DW'(8'h10 + i % 4)) begin
                    failures++;
                    $display("FAIL rr_order[%0d]: got id=%0d d=%h expected id=%0d d=%h",
                             i, out_ids[base+i], out_data[base+i], i % 4, 8'h10 + i % 4);
                end
            end
        end
        drain(20);
    endtask

    task automatic test_packet_lock();
        int base;
        int exp_id [6];
        logic [DW-1:0] exp_d [6];
        exp_id = '{0, 1, 1, 1, 2, 0};
        exp_d  = '{8'h01, 8'hA1, 8'hA2, 8'hA3, 8'h22, 8'h02};
        en = 4'b0001;
        base = out_ids.size();
        push_beat(0, 8'h01, 1'b1);
        cycle();
        push_beat(1, 8'hA1, 1'b0);
        push_beat(1, 8'hA2, 1'b0);
        push_beat(1, 8'hA3, 1'b1);
        push_beat(0, 8'h02, 1'b1);
        push_beat(2, 8'h22, 1'b1);
        en = 4'b0111;
        cycle();
        checks++;
        if (dbg_state !== ARB_LOCKED) begin
            failures++;
            $display("FAIL lock_state: got %0d expected LOCKED", dbg_state);
        end
        drain(30);
        checks++;
        if (out_ids.size() - base != 6) begin
            failures++;
            $display("FAIL lock_count: got %0d beats expected 6", out_ids.size() - base);
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (out_ids[base+i] != exp_id[i] || out_data[base+i] !== exp_d[i]) begin
                    failures++;
                    $display("FAIL lock_order[%0d]: got id=%0d d=%h expected id=%0d d=%h",
                             i, out_ids[base+i], out_data[base+i], exp_id[i], exp_d[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int base;
        base = out_ids.size();
        push_beat(0, 8'hC0, 1'b1);
        push_beat(0, 8'hC1, 1'b1);
        push_beat(0, 8'hC2, 1'b1);
        en = 4'b0001;
        bus.m_ready_i = 1'b1;
        cycle();
        bus.m_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            checks++;
            if (bus.m_valid_o !== 1'b1 || bus.m_data_o !== 8'hC0 || bus.s_ready_o !== 4'b0000) begin
                failures++;
                $display("FAIL stall_hold: got v=%b d=%h rdy=%b expected 1/c0/0000",
                         bus.m_valid_o, bus.m_data_o, bus.s_ready_o);
            end
        end
        bus.m_ready_i = 1'b1;
        drain(20);
        checks++;
        if (out_ids.size() - base != 3 || out_data[base] !== 8'hC0 || out_data[base+1] !== 8'hC1
            || out_data[out_data.size()-1] !== 8'hC2) begin
            failures++;
            $display("FAIL stall_release: got %0d beats expected c0,c1,c2", out_ids.size() - base);
        end
    endtask

    task automatic test_wrap_and_reset();
        int base;
        apply_reset();
        bus.m_ready_i = 1'b1;
        en = 4'b0100;
        base = out_ids.size();
        push_beat(2, 8'h50, 1'b1);
        cycle();
        push_beat(3, 8'h53, 1'b1);
        push_beat(0, 8'h54, 1'b1);
        en = 4'b1001;
        drain(20);
        checks++;
        if (out_ids.size() - base != 3 || out_ids[base+1] != 3 || out_ids[base+2] != 0) begin
            failures++;
            $display("FAIL wrap_order: got %0d beats, ids %0d,%0d expected 3 then 0",
                     out_ids.size() - base, out_ids[out_ids.size()-2], out_ids[out_ids.size()-1]);
        end
        en = 4'b0010;
        push_beat(1, 8'hB1, 1'b0);
        push_beat(1, 8'hB2, 1'b0);
        push_beat(1, 8'hB3, 1'b1);
        cycle();
        cycle();
        checks++;
        if (bus.m_valid_o !== 1'b1 || dbg_state !== ARB_LOCKED) begin
            failures++;
            $display("FAIL midpkt_pre: got v=%b state=%0d expected 1/LOCKED", bus.m_valid_o, dbg_state);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.m_valid_o !== 1'b0 || dbg_state !== ARB_IDLE || bus.m_data_o !== 8'h00) begin
            failures++;
            $display("FAIL midpkt_reset: got v=%b state=%0d d=%h expected 0/IDLE/00",
                     bus.m_valid_o, dbg_state, bus.m_data_o);
        end
        bus.s_valid_i = '0;
        en = '0;
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        base = out_ids.size();
        push_beat(1, 8'h77, 1'b1);
        en = 4'b0010;
        drain(20);
        checks++;
        if (out_ids.size() - base != 1 || out_data[out_data.size()-1] !== 8'h77) begin
            failures++;
            $display("FAIL post_reset: got %0d beats expected single 77", out_ids.size() - base);
        end
    endtask

`ifdef ARB_STATS_EN
    task automatic test_stats();
        apply_reset();
        bus.m_ready_i = 1'b1;
        bus.s_data_i  = '0;
        bus.s_last_i  = 4'b0100;
        bus.s_valid_i = 4'b0100;
        repeat (100) @(negedge clk);
        bus.s_valid_i = '0;
        @(negedge clk);
        checks++;
        if (stats !== {16'd0, 16'd100, 16'd0, 16'd0}) begin
            failures++;
            $display("FAIL stats_count: got %h expected req2=100 others 0", stats);
        end
        bus.s_valid_i = 4'b0100;
        repeat (70000) @(negedge clk);
        bus.s_valid_i = '0;
        @(negedge clk);
        checks++;
        if (stats !== {16'd0, 16'hFFFF, 16'd0, 16'd0}) begin
            failures++;
            $display("FAIL stats_saturate: got %h expected req2=ffff others 0", stats);
        end
    endtask
`endif

    initial begin
        bus.s_valid_i = '0;
        bus.s_data_i  = '0;
        bus.s_last_i  = '0;
        bus.m_ready_i = 1'b1;
        en = '0;
        clear_model();
        test_reset();
        test_round_robin();
        test_packet_lock();
        test_backpressure();
        test_wrap_and_reset();
`ifdef ARB_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

endmodule
